// File: rtl/lutram_mp.sv
// lutram_mp: multi-port distributed RAM model with bank-decoded writes and an INIT scrubber.
// Define LUTRAM_MP_OUTREG_EN to register every read port (1-cycle latency, cleared by RST).
module lutram_mp #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_RD = 3,
  parameter int BANK_BITS = 2,
  parameter logic [BANK_BITS-1:0] BANK_MASK = '1,
  parameter logic [BANK_BITS-1:0] BANK_SPACE = '0,
  parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] INIT = '0,
  parameter logic IS_CLK_INVERTED = 1'b0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           WE,
  input  logic [ADDR_WIDTH+BANK_BITS-1:0] WADR,
  input  logic [DATA_WIDTH-1:0]          DI,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   RADR,
  output logic [NUM_RD*DATA_WIDTH-1:0]   DO,
  input  logic                           CLR,
  output logic                           BUSY,
  output logic                           DONE
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int MW = DEPTH*DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, SCRUB, FIN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic                    clk_int;
  logic                    bank_hit;
  logic                    user_we;
  logic [ADDR_WIDTH-1:0]   wa;
  logic [BANK_BITS-1:0]    wbank;

  // Flat word array; time-zero contents come from INIT.
  logic [MW-1:0] mem = INIT;

  assign clk_int  = CLK ^ IS_CLK_INVERTED;
  assign wa       = WADR[ADDR_WIDTH-1:0];
  assign wbank    = WADR[ADDR_WIDTH +: BANK_BITS];
  assign bank_hit = &(BANK_MASK | ~(wbank ^ BANK_SPACE));
  assign user_we  = WE && !BUSY && bank_hit;

  always_ff @(posedge clk_int) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CLR) begin
            state <= SCRUB;
            ptr   <= '0;
            BUSY  <= 1'b1;
          end
        end
        SCRUB: begin
          if (ptr == LAST) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        FIN: begin
          if (CLR) begin
            state <= SCRUB;
            ptr   <= '0;
            BUSY  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Reset wins over both the scrub write and a user write on the same edge.
  always_ff @(posedge clk_int) begin
    if (!RST) begin
      if (state == SCRUB)
        mem[int'(ptr)*DATA_WIDTH +: DATA_WIDTH] <=
          INIT[int'(ptr)*DATA_WIDTH +: DATA_WIDTH];
      else if (user_we)
        mem[int'(wa)*DATA_WIDTH +: DATA_WIDTH] <= DI;
    end
  end

`ifdef LUTRAM_MP_OUTREG_EN
  always_ff @(posedge clk_int) begin
    if (RST) begin
      DO <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++)
        DO[p*DATA_WIDTH +: DATA_WIDTH] <=
          mem[int'(RADR[p*ADDR_WIDTH +: ADDR_WIDTH])*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`else
  always_comb begin
    DO = '0;
    for (int p = 0; p < NUM_RD; p++)
      DO[p*DATA_WIDTH +: DATA_WIDTH] =
        mem[int'(RADR[p*ADDR_WIDTH +: ADDR_WIDTH])*DATA_WIDTH +: DATA_WIDTH];
  end
`endif

endmodule

// File: tb/tb_lutram_mp.sv
// tb_lutram_mp: scoreboard bench for lutram_mp (asynchronous-read build).
// Stimulus queues expected values; a negedge monitor pops and compares.
module tb_lutram_mp;

  localparam int DW = 4;
  localparam int AW = 6;
  localparam int NR = 3;
  localparam int BB = 2;
  localparam int DEPTH = 64;

  function automatic logic [DEPTH*DW-1:0] mk_init();
    logic [DEPTH*DW-1:0] r;
    r = '0;
    for (int a = 0; a < DEPTH; a++) r[a*DW +: DW] = 4'(a + 13);
    return r;
  endfunction

  localparam logic [DEPTH*DW-1:0] INIT_V = mk_init();

  logic clk = 1'b0;
  logic RST, WE, CLR;
  logic [AW+BB-1:0] WADR;
  logic [DW-1:0] DI;
  logic [NR*AW-1:0] RADR;
  logic [NR*DW-1:0] DO;
  logic BUSY, DONE;

  lutram_mp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_RD(NR),
    .BANK_BITS(BB),
    .BANK_MASK(2'b10),
    .BANK_SPACE(2'b01),
    .INIT(INIT_V),
    .IS_CLK_INVERTED(1'b0)
  ) dut (
    .CLK(clk),
    .RST(RST),
    .WE(WE),
    .WADR(WADR),
    .DI(DI),
    .RADR(RADR),
    .DO(DO),
    .CLR(CLR),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    int         port;
    logic [3:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  logic [3:0] ref_mem [DEPTH];
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [3:0] act;
      e = sb.pop_front();
      case (e.kind)
        0: act = DO[e.port*DW +: DW];
        1: act = {3'b000, BUSY};
        default: act = {3'b000, DONE};
      endcase
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(int kind, int port, logic [3:0] v, string nm);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.v = v;
    e.nm = nm;
    sb.push_back(e);
  endfunction

  task automatic rd(int p, int a, string nm);
    RADR[p*AW +: AW] = 6'(a);
    chk(0, p, ref_mem[a], nm);
  endtask

  task automatic st(logic b, logic d, string nm);
    chk(1, 0, {3'b000, b}, {nm, "_busy"});
    chk(2, 0, {3'b000, d}, {nm, "_done"});
  endtask

  task automatic wr(logic [1:0] bank, int a, logic [3:0] d, bit hit);
    WE = 1'b1;
    WADR = {bank, 6'(a)};
    DI = d;
    cyc();
    WE = 1'b0;
    if (hit) ref_mem[a] = d;
  endtask

  task automatic ref_init(int upto);
    for (int a = 0; a < upto; a++) ref_mem[a] = 4'(a + 13);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; WE = 1'b0; CLR = 1'b0;
    WADR = '0; DI = '0; RADR = '0;
    ref_init(DEPTH);
    cyc(); cyc();
    RST = 1'b0;
    st(0, 0, "reset");
    rd(0, 0, "init_w0");
    cyc();

    rd(0, 5, "wr_old_p0");
    rd(1, 5, "wr_old_p1");
    wr(2'b01, 5, 4'hA, 1);
    rd(0, 5, "wr_new_p0");
    rd(1, 5, "wr_new_p1");
    rd(2, 0, "wr_p2_other");
    cyc();

    wr(2'b00, 7, 4'h3, 0); rd(0, 7, "bank00_miss"); cyc();
    wr(2'b10, 7, 4'h3, 0); rd(0, 7, "bank10_miss"); cyc();
    wr(2'b01, 7, 4'h3, 1); rd(0, 7, "bank01_hit"); cyc();
    wr(2'b11, 7, 4'h8, 1); rd(0, 7, "bank11_hit"); cyc();
    rd(0, 7, "mp_p0"); rd(1, 5, "mp_p1"); rd(2, 9, "mp_p2"); cyc();

    wr(2'b01, 2, 4'h1, 1);
    wr(2'b01, 9, 4'hF, 1);
    CLR = 1'b1;
    st(0, 0, "clr_edge");
    cyc();
    CLR = 1'b0;
    RADR[0 +: AW] = 6'd2;
    RADR[2*AW +: AW] = 6'd9;
    for (int k = 0; k < DEPTH; k++) begin
      st(1, 0, "scrub");
      if (k == 3) begin
        WE = 1'b1; WADR = {2'b01, 6'd2}; DI = 4'h5;
      end
      if (k == 4) begin
        WE = 1'b0;
        chk(0, 0, 4'hF, "scrub_we_drop");
      end
      if (k == 9) chk(0, 2, 4'hF, "scrub_w9_before");
      if (k == 10) chk(0, 2, 4'h6, "scrub_w9_after");
      cyc();
    end
    ref_init(DEPTH);
    st(0, 1, "fin");
    wr(2'b01, 1, 4'h9, 1);
    st(0, 0, "post_fin");
    rd(0, 9, "scrub_w9");
    rd(1, 1, "fin_write");
    rd(2, 2, "scrub_w2");
    cyc();

    wr(2'b01, 5, 4'h0, 1);
    wr(2'b01, 10, 4'hE, 1);
    wr(2'b01, 40, 4'h1, 1);
    CLR = 1'b1;
    st(0, 0, "clr2_edge");
    cyc();
    CLR = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      st(1, 0, "scrub2");
      if (k == 10) RST = 1'b1;
      cyc();
    end
    RST = 1'b0;
    ref_init(10);
    st(0, 0, "after_rst");
    rd(0, 5, "rst_scrubbed5");
    rd(1, 10, "rst_kept10");
    rd(2, 40, "rst_kept40");
    cyc();
    repeat (5) begin
      st(0, 0, "no_done");
      cyc();
    end

    CLR = 1'b1;
    st(0, 0, "b2b_clr");
    cyc();
    for (int k = 0; k < DEPTH; k++) begin
      st(1, 0, "b2b_busy1");
      cyc();
    end
    st(0, 1, "b2b_fin1");
    cyc();
    CLR = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      st(1, 0, "b2b_busy2");
      cyc();
    end
    st(0, 1, "b2b_fin2");
    cyc();
    ref_init(DEPTH);
    st(0, 0, "b2b_idle");
    rd(0, 10, "b2b_w10");
    rd(1, 40, "b2b_w40");
    cyc();

    @(negedge clk);
    #1;
    checks++;
    if (DO[0 +: DW] !== ref_mem[10]) begin
      errors++;
      $display("FAIL end_w10: got %h expected %h",
        DO[0 +: DW], ref_mem[10]);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL end_busy: got %b expected 0", BUSY);
    end
    checks++;
    if (DONE !== 1'b0) begin
      errors++;
      $display("FAIL end_done: got %b expected 0", DONE);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lutram_mp.md
# lutram_mp

Parametrised multi-port distributed-RAM simulation model: one synchronous write port and NUM_RD asynchronous read ports over a DEPTH×DATA_WIDTH array. It supports bank decoding on extra write-address bits and includes a built-in scrub sequencer that restores INIT contents on request. It sits beside the single-bit LUTRAM sim models and stands in for multi-LUT RAM macros (RAM32M/RAM64M-style groupings) in Icarus-safe simulation of placed netlists.

## Interface
- DATA_WIDTH, 4, bits per word
- ADDR_WIDTH, 6, word address bits; DEPTH = 2**ADDR_WIDTH
- NUM_RD, 3, number of read ports (≥1)
- BANK_BITS, 2, extra write-address bits used for bank select (≥1)
- BANK_MASK, all ones, per-bank-bit ignore flag (1 = don't care)
- BANK_SPACE, 0, required value of each unmasked bank bit
- INIT, 0, DEPTH*DATA_WIDTH bits; word a = INIT[a*DATA_WIDTH +: DATA_WIDTH]
- IS_CLK_INVERTED, 1'b0, active edge = posedge of CLK ^ IS_CLK_INVERTED

Ports:
- CLK  in  1  clock; single clock domain
- RST  in  1  synchronous, active-high reset; sampled on the active edge
- WE  in  1  write enable
- WADR  in  ADDR_WIDTH+BANK_BITS  write address; low ADDR_WIDTH bits = word, upper bits = bank
- DI  in  DATA_WIDTH  write data
- RADR  in  NUM_RD*ADDR_WIDTH  read addresses; port p = RADR[p*ADDR_WIDTH +: ADDR_WIDTH]
- DO  out  NUM_RD*DATA_WIDTH  read data; port p = DO[p*DATA_WIDTH +: DATA_WIDTH]
- CLR  in  1  scrub request (level, sampled at the edge)
- BUSY  out  1  scrub in progress
- DONE  out  1  one-cycle pulse on scrub completion

## Operation
- Array is initialised to INIT at time 0. RST does not alter array contents.
- User write: at the edge, when WE && !BUSY && bank_hit, mem[WADR[ADDR_WIDTH-1:0]] <= DI.
  - bank_hit = AND over i of (BANK_MASK[i] || WADR[ADDR_WIDTH+i] == BANK_SPACE[i]).
- Read: each DO port is a combinational function of mem[RADR port]. Ports are independent, and any number of ports may share an address.
- FSM states:
  - IDLE: BUSY=0. CLR=1 goes to SCRUB with ptr <= 0.
  - SCRUB: BUSY=1. Each cycle writes mem[ptr] <= INIT word ptr and increments ptr. User writes are ignored. CLR is ignored. Bank decode does not apply. Writing ptr == DEPTH-1 goes to FIN.
  - FIN: DONE=1 for this cycle, BUSY=0. Next state is IDLE, or SCRUB if CLR=1 (restart, ptr <= 0).
- In FIN, user writes are accepted (BUSY=0).
- ptr is ADDR_WIDTH bits wide and does not wrap. Termination is on compare, not overflow.
- RST during SCRUB: abort to IDLE and clear ptr. Words already scrubbed keep INIT; the rest keep prior contents. RST has priority over CLR and over the write in that same cycle.

## Timing
- Reset values: BUSY=0, DONE=0, FSM=IDLE, ptr=0. DO is not reset (unregistered build); it reflects the array.
- Write to read visibility: DO changes in the same timestep as the active edge that performs the write. Before the edge, DO shows old data.
- Same-edge write and read of the same address: the read sees old data before the edge and new data after.
- CLR asserted at edge n: BUSY=1 from n+1. Words 0..DEPTH-1 are written at edges n+1..n+DEPTH. DONE=1 and BUSY=0 during the cycle after edge n+DEPTH.
- Scrub duration is exactly DEPTH cycles. Minimum CLR-to-DONE latency is DEPTH+1 edges.

## Configuration
- LUTRAM_MP_OUTREG_EN defined: each DO port is registered at the active edge (DO <= mem[RADR]). Read latency is 1 cycle. RST clears all DO to 0. A same-edge write to the read address returns old data.
- Not defined: DO is asynchronous as above, with 0-cycle latency and no reset.

## Test plan
- Write/read: DATA_WIDTH=4, write 0xA to addr 5 with WADR bank bits 0, RADR port0=5 → DO port0 = 0xA after the edge (the next edge with OUTREG). Port1=5 also shows 0xA.
- Bank decode: BANK_MASK=2'b10, BANK_SPACE=2'b01. Write 0x3 to addr 7 with bank bit0=0 → mem[7] unchanged. With bank bit0=1 → mem[7]=0x3, and bit1 toggling has no effect.
- Scrub: INIT word 9 = 0x6, write 0xF to addr 9, pulse CLR → BUSY high for exactly 64 cycles, DONE pulses once, then DO(addr 9) = 0x6. A WE during BUSY to addr 2 is dropped.
- Reset mid-scrub: CLR, then RST at cycle 10 of SCRUB → BUSY=0 the next cycle, addrs 0..9 hold INIT, addrs ≥10 hold prior data, no DONE pulse.
- Back-to-back: CLR held high through FIN → DONE pulses, SCRUB restarts immediately, 64 more BUSY cycles.
- OUTREG build: assert RST → all DO = 0. Same-edge write 0x5 / read addr 3 (old 0x2) → DO=0x2, then 0x5 on the following edge.
